// File: rtl/iir_pkg.sv
// Shared types and widths for the iir filter and its downstream stages.
package iir_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 10;

  typedef logic [Y_W-1:0] y_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with registered storage and occupancy count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (PTR_W + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: storage is reset so m_data reads 0 while empty; DEPTH is small, so this is cheap flops, not RAM.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/iir_decimator.sv
// Block-average decimator for the iir output stream, buffered by a small FIFO
// with valid/ready drain and sticky overflow on dropped results.
module iir_decimator
  import iir_pkg::*;
#(
  parameter int LOG2_DECIM = 2,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  y_t                     y_in,
  output y_t                     m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  localparam int N     = 1 << LOG2_DECIM;
  localparam int ACC_W = Y_W + LOG2_DECIM;
  localparam int CNT_W = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;

  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic             last;
  logic             push_req;
  logic             pop;
  logic             drop;
  logic             full;
  logic             empty;
  y_t               result;

  always_comb begin
    // NOTE: every output of this block gets a value on every path, so no latch is inferred.
    sum      = ((cnt == '0) ? '0 : acc) + ACC_W'(y_in);
    last     = (cnt == CNT_W'(N - 1));
    result   = y_t'(sum >> LOG2_DECIM);
    push_req = en & last;
    pop      = m_valid & m_ready;
    drop     = push_req & full & ~pop;
  end

  assign m_valid = ~empty;

  // The first sample of a block discards the old sum, so acc needs no clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + 1'b1;
      acc <= sum;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (Y_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .pop     (pop),
    .wdata   (result),
    .rdata   (m_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

endmodule

// File: doc/iir_decimator.md
# iir_decimator

Downstream stage of the `iir` filter. It takes the 10-bit filter output `y` every enabled cycle and averages blocks of 2^LOG2_DECIM consecutive samples. Each block average goes into a small output FIFO, which is drained over a valid/ready interface. It rate-reduces the filter stream and absorbs consumer backpressure, with sticky overflow reporting.

## Interface
- `LOG2_DECIM`, default 2: decimation factor N = 2^LOG2_DECIM; legal range 0–4.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `clk`  in  1: rising-edge clock, shared with `iir`.
- `reset_n`  in  1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `en`  in  1: `y_in` is a valid sample this cycle.
- `y_in`  in  10: unsigned filter output, connected to `iir.y`.
- `m_data`  out  10: FIFO head sample.
- `m_valid`  out  1: FIFO not empty.
- `m_ready`  in  1: consumer accepts head this cycle.
- `level`  out  $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
- `overflow`  out  1: sticky flag; a decimated result was dropped.
- `clr_ovf`  in  1: synchronous clear of `overflow`.

## Operation
- **Accepted sample:** `en`=1 at a rising edge.
  - `en`=0 holds all decimator state.
- **Phase counter `cnt`:** counts 0..N-1 on each accepted sample, then wraps to 0.
- **Accumulator `acc`:** width 10+LOG2_DECIM; unsigned; cannot overflow, max 1023·N.
  - Accepted sample with `cnt`=0: `acc` ← `y_in`.
  - Otherwise: `acc` ← `acc` + `y_in`.
- **Block result:** on the accepted sample with `cnt`=N-1, result = (`acc` + `y_in`) >> LOG2_DECIM.
  - Truncating, no rounding; result is 10 bits.
  - This is the push request for the cycle.
  - With N=1, every accepted sample is pushed unchanged.
- **FIFO:** synchronous, registered storage. `m_data` is read combinationally from the head entry (show-ahead).
  - Pop = `m_valid` & `m_ready`.
  - Empty with a push: the push is stored and nothing is popped. The FIFO never passes data through in the same cycle.
  - Full, push with pop in the same cycle: both occur; `level` is unchanged.
  - Full, push without pop: the result is dropped and `overflow` ← 1. FIFO contents are unchanged.
  - `m_ready` while empty: ignored.
  - Read/write pointers wrap modulo DEPTH.
- **Overflow flag:**
  - `clr_ovf`=1 clears `overflow`.
  - A drop in the same cycle as `clr_ovf` wins: `overflow` stays 1.
- **Reset values:** `cnt`=0, `acc`=0, FIFO empty, storage 0, pointers 0.
  - Outputs: `m_valid`=0, `m_data`=0, `level`=0, `overflow`=0.
  - Reset during a partial block discards it; the next accepted sample starts a new block at `cnt`=0.

## Timing
- **Latency:** the Nth accepted sample of a block is sampled at edge k. The result is written at edge k, and `m_valid`/`m_data` show it after edge k.
  - The result is poppable at edge k+1 at the earliest.
- **Throughput:** one result per N accepted samples; one pop per cycle maximum.
- `level` updates at the same edge as the push/pop. It reflects the state after that edge.
- **Outputs:** `m_valid`, `level` and `overflow` are register-derived. `m_data` is a mux of registers. No input→output combinational path.
- **Handshake rules:**
  - Once `m_valid`=1, `m_data` stays stable until popped.
  - `m_valid` does not drop without a pop.

## Structure
- **Package `iir_pkg`:**
  - `X_W`=8 and `Y_W`=10, shared with `iir`.
  - Typedef `y_t` = logic [Y_W-1:0].
  - This block uses `y_t` for `y_in`/`m_data`.
- **Sub-module `sync_fifo`:**
  - Parameterised by width and DEPTH.
  - Ports: push/pop, data, full/empty, level.
  - `iir_decimator` holds only `cnt`, `acc`, push generation and overflow logic.

## Test plan
All with default parameters (N=4, DEPTH=4) unless stated.
- **Reset:** hold `reset_n`=0, toggle `en`/`y_in`, then release -> `m_valid`=0, `m_data`=0, `level`=0, `overflow`=0 throughout.
- **Impulse response:** `y_in` sequence 508,254,127,63,31,15,7,3,1,0,0,0 with `en`=1, `m_ready`=1 -> outputs 238, 14, 0.
  - Each `m_valid` rises in the cycle after the 4th, 8th and 12th accepted sample.
- **Enable gaps:** `y_in`=100 with `en` pattern 1,0,1,0,0,1,1 -> exactly one result, 100, after the 4th accepted sample. Held cycles do not contribute.
- **Backpressure and overflow:** `m_ready`=0, `y_in`=1023, `en`=1 for 20 cycles -> `level` goes 1,2,3,4 after samples 4,8,12,16; the 5th result is dropped and `overflow`=1.
  - Then pulse `clr_ovf` -> `overflow`=0.
  - Then `m_ready`=1 -> four pops of 1023, `level` 3→0, `m_valid`=0.
- **Full with simultaneous push and pop:** `level`=4, a push coincides with `m_ready`=1 -> the head pops, the new result is stored, `level` stays 4, `overflow` stays 0.
- **Reset mid-block:** accept 2 samples of 900, assert `reset_n` low asynchronously mid-cycle, release, then accept 4 samples of 40 -> single output 40 with no contribution from 900; all state is zero immediately on `reset_n` falling.
